// File: rtl/instruction_decode_pkg.sv
// Shared widths, the instruction class enum, RV32I opcodes and the ID/EX record.
package instruction_decode_pkg;

  localparam int DATA_WIDTH            = 32;
  localparam int PROGRAM_ADDRESS_WIDTH = 32;
  localparam int NUM_REGS              = 32;

  typedef enum logic [2:0] {
    R_type,
    I_type,
    S_type,
    B_type,
    U_type,
    J_type
  } instruction_op_type;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // All-zero value is the bubble: valid=0, controls=0, optype=R_type.
  typedef struct packed {
    logic                             valid;
    logic [PROGRAM_ADDRESS_WIDTH-1:0] pc;
    instruction_op_type               optype;
    logic [31:0]                      imm;
    logic [DATA_WIDTH-1:0]            rs1_data;
    logic [DATA_WIDTH-1:0]            rs2_data;
    logic [4:0]                       rs1;
    logic [4:0]                       rs2;
    logic [4:0]                       rd;
    logic [2:0]                       funct3;
    logic                             funct7_5;
    logic                             reg_write;
    logic                             mem_read;
    logic                             mem_write;
    logic                             illegal;
  } idex_t;

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 integer register file: two async read ports, one write port, x0 tied to zero.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int NREGS = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            raddr1_i,
  input  logic [4:0]            raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle write-back bypasses storage so decode never sees a stale operand.
  always_comb begin
    if (raddr1_i == 5'd0)                  rdata1_o = '0;
    else if (we_i && waddr_i == raddr1_i)  rdata1_o = wdata_i;
    else                                   rdata1_o = regs_q[raddr1_i];
  end

  always_comb begin
    if (raddr2_i == 5'd0)                  rdata2_o = '0;
    else if (we_i && waddr_i == raddr2_i)  rdata2_o = wdata_i;
    else                                   rdata2_o = regs_q[raddr2_i];
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: classifies the instruction, builds the immediate, reads operands,
// detects load-use hazards and registers everything into the ID/EX slot.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [31:0]                      instruction,
  input  logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_in,
  input  logic                             stall,
  input  logic                             flush,
  input  logic                             wb_we,
  input  logic [4:0]                       wb_rd,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  input  logic                             ex_mem_read,
  input  logic [4:0]                       ex_rd,
  output logic                             hazard_stall,
  output logic                             valid_out,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_out,
  output instruction_op_type               optype,
  output logic [31:0]                      imm,
  output logic [DATA_WIDTH-1:0]            rs1_data,
  output logic [DATA_WIDTH-1:0]            rs2_data,
  output logic [4:0]                       rs1,
  output logic [4:0]                       rs2,
  output logic [4:0]                       rd,
  output logic [2:0]                       funct3,
  output logic                             funct7_5,
  output logic                             reg_write,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic                             illegal
);

  idex_t idex_q, idex_d, dec;
  logic  use_rs1, use_rs2;
  logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;

  register_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (instruction[19:15]),
    .raddr2_i (instruction[24:20]),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = valid_in;
    dec.pc       = pc_in;
    dec.rs1      = instruction[19:15];
    dec.rs2      = instruction[24:20];
    dec.rd       = instruction[11:7];
    dec.funct3   = instruction[14:12];
    dec.funct7_5 = instruction[30];
    dec.rs1_data = rf_rdata1;
    dec.rs2_data = rf_rdata2;
    unique case (instruction[6:0])
      OP_R: begin
        dec.optype    = R_type;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.optype    = I_type;
        dec.imm       = {{20{instruction[31]}}, instruction[31:20]};
        dec.reg_write = 1'b1;
        dec.mem_read  = (instruction[6:0] == OP_LOAD);
        use_rs1       = 1'b1;
      end
      OP_STORE: begin
        dec.optype    = S_type;
        dec.imm       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        dec.mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        dec.optype = B_type;
        dec.imm    = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.optype    = U_type;
        dec.imm       = {instruction[31:12], 12'b0};
        dec.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec.optype    = J_type;
        dec.imm       = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hazard_stall = valid_in && ex_mem_read && (ex_rd != 5'd0) &&
                        ((use_rs1 && ex_rd == dec.rs1) || (use_rs2 && ex_rd == dec.rs2));

  // Flush beats stall beats hazard; a flush or a hazard leaves a zeroed bubble.
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (stall) begin
      idex_d = idex_q;
    end else if (hazard_stall) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
      if (!valid_in) begin
        idex_d.reg_write = 1'b0;
        idex_d.mem_read  = 1'b0;
        idex_d.mem_write = 1'b0;
        idex_d.illegal   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign valid_out = idex_q.valid;
  assign pc_out    = idex_q.pc;
  assign optype    = idex_q.optype;
  assign imm       = idex_q.imm;
  assign rs1_data  = idex_q.rs1_data;
  assign rs2_data  = idex_q.rs2_data;
  assign rs1       = idex_q.rs1;
  assign rs2       = idex_q.rs2;
  assign rd        = idex_q.rd;
  assign funct3    = idex_q.funct3;
  assign funct7_5  = idex_q.funct7_5;
  assign reg_write = idex_q.reg_write;
  assign mem_read  = idex_q.mem_read;
  assign mem_write = idex_q.mem_write;
  assign illegal   = idex_q.illegal;

endmodule
